// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants for the register-file writeback arbiter and its users.
package regfile_wb_arbiter_pkg;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;

  localparam int REQ_ALU  = 0;
  localparam int REQ_LOAD = 1;
  localparam int REQ_MDU  = 2;

  localparam logic [ADDR_W-1:0] ZERO_REG = '0;
endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from ptr with wrap,
// plus the pointer value to load after a grant (one past the winner).
module rr_arbiter #(
  parameter int N     = 3,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] next_ptr
);
  int   idx;
  logic found;

  always_comb begin
    grant    = '0;
    next_ptr = ptr;
    found    = 1'b0;
    idx      = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        next_ptr   = (idx == N - 1) ? '0 : PTR_W'(idx + 1);
        found      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port among writeback requesters and keeps a
// per-register pending-write scoreboard for read-after-write stalls.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = regfile_wb_arbiter_pkg::DATA_W,
  parameter int ADDR_W  = regfile_wb_arbiter_pkg::ADDR_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_reg,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      rsv_valid,
  input  logic [ADDR_W-1:0]         rsv_reg,
  input  logic [ADDR_W-1:0]         rd_reg1,
  input  logic [ADDR_W-1:0]         rd_reg2,
  output logic                      rd_busy1,
  output logic                      rd_busy2,
  output logic [NUM_REGS-1:0]       busy_vec,
  output logic                      write_enable,
  output logic [ADDR_W-1:0]         write_reg,
  output logic [DATA_W-1:0]         write_data
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]    rr_ptr;
  logic [PTR_W-1:0]    rr_next;
  logic [NUM_REQ-1:0]  grant;
  logic                transfer;
  logic [ADDR_W-1:0]   sel_reg;
  logic [DATA_W-1:0]   sel_data;
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_nxt;

  // Handshake: a transfer happens on a rising edge where req_valid[i] and
  // req_ready[i] are both high; ready is derived from valid, never the reverse,
  // and the requester holds valid/reg/data stable until it is granted.
  rr_arbiter #(.N(NUM_REQ), .PTR_W(PTR_W)) u_rr (
    .req      (req_valid),
    .ptr      (rr_ptr),
    .grant    (grant),
    .next_ptr (rr_next)
  );

  assign req_ready = grant;
  assign transfer  = |grant;

  always_comb begin
    sel_reg  = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_reg  = req_reg[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr       <= '0;
      write_enable <= 1'b0;
      write_reg    <= '0;
      write_data   <= '0;
    end else begin
      write_enable <= 1'b0;
      if (transfer) begin
        rr_ptr       <= rr_next;
        write_reg    <= sel_reg;
        write_data   <= sel_data;
        write_enable <= (sel_reg != ADDR_W'(ZERO_REG));
      end
    end
  end

  // A new reservation is younger than the write retiring this cycle, so set wins.
  always_comb begin
    busy_nxt = busy;
    if (write_enable) busy_nxt[write_reg] = 1'b0;
    if (rsv_valid && (rsv_reg != ADDR_W'(ZERO_REG))) busy_nxt[rsv_reg] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) busy <= '0;
    else        busy <= busy_nxt;
  end

  assign busy_vec = busy;
  assign rd_busy1 = busy[rd_reg1];
  assign rd_busy2 = busy[rd_reg2];
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus a random stream checked
// against a cycle-level reference model of arbitration, write stage and scoreboard.
module tb_regfile_wb_arbiter;
  localparam int N = 3;
  localparam int A = 5;
  localparam int D = 32;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*A-1:0] req_reg = '0;
  logic [N*D-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic           rsv_valid = 1'b0;
  logic [A-1:0]   rsv_reg = '0;
  logic [A-1:0]   rd_reg1 = '0;
  logic [A-1:0]   rd_reg2 = '0;
  logic           rd_busy1, rd_busy2;
  logic [31:0]    busy_vec;
  logic           write_enable;
  logic [A-1:0]   write_reg;
  logic [D-1:0]   write_data;

  int errors = 0;
  int checks = 0;

  // reference model state
  int           m_ptr;
  logic [31:0]  m_busy;
  logic         m_we;
  logic [A-1:0] m_wr;
  logic [D-1:0] m_wd;
  logic [N-1:0] last_grant;
  logic [A+D-1:0] exp_q[$];

  regfile_wb_arbiter #(.NUM_REQ(N), .DATA_W(D), .ADDR_W(A)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_reg(req_reg), .req_data(req_data), .req_ready(req_ready),
    .rsv_valid(rsv_valid), .rsv_reg(rsv_reg),
    .rd_reg1(rd_reg1), .rd_reg2(rd_reg2), .rd_busy1(rd_busy1), .rd_busy2(rd_busy2),
    .busy_vec(busy_vec), .write_enable(write_enable), .write_reg(write_reg), .write_data(write_data)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  function automatic logic [N-1:0] model_grant(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (ptr + k) % N;
      if (v[i]) return N'(1) << i;
    end
    return '0;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_busy = '0; m_we = 1'b0; m_wr = '0; m_wd = '0;
    last_grant = '0;
    exp_q.delete();
  endtask

  // Advance one clock edge and apply the architectural rules to the model.
  task automatic tick();
    logic [N-1:0] g;
    logic [A-1:0] r;
    logic [D-1:0] d;
    g = model_grant(req_valid, m_ptr);
    @(posedge clk);
    if (!reset) begin
      model_reset();
    end else begin
      if (m_we) m_busy[m_wr] = 1'b0;
      if (rsv_valid && rsv_reg != 0) m_busy[rsv_reg] = 1'b1;
      last_grant = g;
      m_we = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (g[i]) begin
          r = req_reg[i*A +: A];
          d = req_data[i*D +: D];
          m_wr = r; m_wd = d; m_we = (r != 0);
          m_ptr = (i + 1) % N;
          if (r != 0) exp_q.push_back({r, d});
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_reset();
    req_valid = 3'b111;
    req_reg   = {5'd7, 5'd6, 5'd5};
    req_data  = {32'hC, 32'hB, 32'hA};
    #1;
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL reset_ready: got %b exp 001", req_ready); end
    repeat (3) begin
      tick();
      checks++; if (write_enable !== 1'b0 || write_reg !== '0 || write_data !== '0) begin
        errors++; $display("FAIL reset_out: we=%b reg=%0d data=%h exp 0/0/0", write_enable, write_reg, write_data);
      end
      checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL reset_busy: got %h exp 0", busy_vec); end
    end
    reset = 1'b1;
    #1;
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL first_grant: got %b exp 001", req_ready); end
    tick();
    checks++; if (write_enable !== 1'b1 || write_reg !== 5'd5 || write_data !== 32'hA) begin
      errors++; $display("FAIL first_write: we=%b reg=%0d data=%h exp 1/5/a", write_enable, write_reg, write_data);
    end
  endtask

  task automatic test_round_robin();
    int cnt[N];
    logic [A+D-1:0] e;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    exp_q.delete();
    for (int c = 0; c < 3 * N; c++) begin
      #1;
      checks++; if (req_ready !== model_grant(req_valid, m_ptr)) begin
        errors++; $display("FAIL rr_ready: got %b exp %b", req_ready, model_grant(req_valid, m_ptr));
      end
      for (int i = 0; i < N; i++) if (req_ready[i]) cnt[i]++;
      tick();
      checks++; if (write_enable !== m_we) begin errors++; $display("FAIL rr_we: got %b exp %b", write_enable, m_we); end
      if (write_enable === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL rr_write: unexpected write reg=%0d", write_reg); end
        else begin
          e = exp_q.pop_front();
          if ({write_reg, write_data} !== e) begin
            errors++; $display("FAIL rr_write: got %0d/%h exp %0d/%h", write_reg, write_data, e[A+D-1:D], e[D-1:0]);
          end
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      checks++; if (cnt[i] !== 3) begin errors++; $display("FAIL fairness: req %0d granted %0d exp 3", i, cnt[i]); end
    end
  endtask

  task automatic test_zero_reg();
    req_valid = 3'b100;
    req_reg   = {5'd0, 5'd6, 5'd5};
    req_data  = {32'hFFFF_FFFF, 32'hB, 32'hA};
    #1;
    checks++; if (req_ready !== 3'b100) begin errors++; $display("FAIL zero_ready: got %b exp 100", req_ready); end
    tick();
    req_valid = '0;
    checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL zero_we: got %b exp 0", write_enable); end
    checks++; if (busy_vec !== m_busy) begin errors++; $display("FAIL zero_busy: got %h exp %h", busy_vec, m_busy); end
    tick();
  endtask

  task automatic test_busy_clear();
    req_valid = '0;
    rsv_valid = 1'b1; rsv_reg = 5'd9; rd_reg1 = 5'd9; rd_reg2 = 5'd5;
    #1;
    checks++; if (rd_busy1 !== 1'b0) begin errors++; $display("FAIL busy_pre: got %b exp 0", rd_busy1); end
    tick();
    rsv_valid = 1'b0;
    checks++; if (rd_busy1 !== 1'b1 || rd_busy2 !== 1'b0) begin
      errors++; $display("FAIL busy_set: got %b/%b exp 1/0", rd_busy1, rd_busy2);
    end
    tick();
    req_valid = 3'b001; req_reg[A-1:0] = 5'd9; req_data[D-1:0] = 32'h99;
    #1;
    checks++; if (req_ready !== 3'b001 || rd_busy1 !== 1'b1) begin
      errors++; $display("FAIL busy_hold: ready=%b busy=%b exp 001/1", req_ready, rd_busy1);
    end
    tick();
    req_valid = '0;
    checks++; if (write_enable !== 1'b1 || write_reg !== 5'd9 || rd_busy1 !== 1'b1) begin
      errors++; $display("FAIL busy_wr: we=%b reg=%0d busy=%b exp 1/9/1", write_enable, write_reg, rd_busy1);
    end
    tick();
    checks++; if (write_enable !== 1'b0 || rd_busy1 !== 1'b0 || busy_vec !== m_busy) begin
      errors++; $display("FAIL busy_clr: we=%b busy=%b vec=%h exp 0/0/%h", write_enable, rd_busy1, busy_vec, m_busy);
    end
  endtask

  task automatic test_set_wins();
    rsv_valid = 1'b1; rsv_reg = 5'd4; rd_reg1 = 5'd4;
    req_valid = 3'b001; req_reg[A-1:0] = 5'd4; req_data[D-1:0] = 32'h44;
    tick();
    req_valid = '0;
    checks++; if (write_enable !== 1'b1 || write_reg !== 5'd4 || rd_busy1 !== 1'b1) begin
      errors++; $display("FAIL setwin_pre: we=%b reg=%0d busy=%b exp 1/4/1", write_enable, write_reg, rd_busy1);
    end
    tick();
    rsv_valid = 1'b0;
    checks++; if (busy_vec[4] !== 1'b1 || busy_vec !== m_busy) begin
      errors++; $display("FAIL set_wins: got %h exp %h", busy_vec, m_busy);
    end
  endtask

  task automatic test_async_reset();
    rsv_valid = 1'b1; rsv_reg = 5'd9;
    req_valid = 3'b001; req_reg[A-1:0] = 5'd7; req_data[D-1:0] = 32'h77;
    tick();
    rsv_valid = 1'b0; req_valid = '0;
    checks++; if (busy_vec !== 32'h0000_0210 || write_enable !== 1'b1) begin
      errors++; $display("FAIL arst_pre: vec=%h we=%b exp 00000210/1", busy_vec, write_enable);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (busy_vec !== 32'h0 || write_enable !== 1'b0 || write_reg !== '0 || write_data !== '0) begin
      errors++; $display("FAIL arst_now: vec=%h we=%b reg=%0d data=%h exp 0", busy_vec, write_enable, write_reg, write_data);
    end
    model_reset();
    req_valid = 3'b110; req_reg = {5'd3, 5'd2, 5'd1};
    tick();
    checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL arst_hold: got %b exp 0", write_enable); end
    req_valid = '0;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_random();
    logic [N-1:0] pend;
    logic [A+D-1:0] e;
    pend = '0;
    exp_q.delete();
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1;
          req_reg[i*A +: A]  = A'($urandom_range(0, 31));
          req_data[i*D +: D] = $urandom;
        end
      end
      req_valid = pend;
      rsv_valid = ($urandom_range(0, 3) == 0);
      rsv_reg   = A'($urandom_range(0, 31));
      rd_reg1   = A'($urandom_range(0, 31));
      rd_reg2   = A'($urandom_range(0, 31));
      #1;
      checks++; if (req_ready !== model_grant(req_valid, m_ptr)) begin
        errors++; $display("FAIL rnd_ready: cyc %0d got %b exp %b", c, req_ready, model_grant(req_valid, m_ptr));
      end
      checks++; if (rd_busy1 !== m_busy[rd_reg1] || rd_busy2 !== m_busy[rd_reg2]) begin
        errors++; $display("FAIL rnd_rdbusy: cyc %0d got %b/%b exp %b/%b", c, rd_busy1, rd_busy2, m_busy[rd_reg1], m_busy[rd_reg2]);
      end
      tick();
      pend = pend & ~last_grant;
      checks++; if (write_enable !== m_we) begin errors++; $display("FAIL rnd_we: cyc %0d got %b exp %b", c, write_enable, m_we); end
      if (write_enable === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL rnd_write: cyc %0d unexpected write", c); end
        else begin
          e = exp_q.pop_front();
          if ({write_reg, write_data} !== e) begin
            errors++; $display("FAIL rnd_write: cyc %0d got %0d/%h exp %0d/%h", c, write_reg, write_data, e[A+D-1:D], e[D-1:0]);
          end
        end
      end
      checks++; if (busy_vec !== m_busy) begin errors++; $display("FAIL rnd_busy: cyc %0d got %h exp %h", c, busy_vec, m_busy); end
    end
    req_valid = '0; rsv_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_zero_reg();
    test_busy_clear();
    test_set_wins();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
